// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO with show-ahead head data and empty/full status
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with sticky overrun/frame-error flags
// UART_RX_FIFO_EN selects a FIFO_DEPTH-entry buffer; otherwise a single holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                   sys_clk_i,
  input  logic                   sys_rstn_i,
  input  logic                   uart_rx_i,
  input  logic                   uart_rd_i,
  input  logic                   uart_clr_i,
  output logic [UART_DATA_W-1:0] uart_dat_o,
  output logic                   uart_valid_o,
  output logic                   uart_ovf_o,
  output logic                   uart_ferr_o
);

  localparam int            BW          = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] HALF_RELOAD = BW'(CLKS_PER_BIT/2 - 1);
  localparam logic [BW-1:0] FULL_RELOAD = BW'(CLKS_PER_BIT - 1);

  logic                   rx_meta;
  logic                   rx_s;
  uart_rx_state_t         state;
  logic [BW-1:0]          baud_cnt;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shift;
  logic                   baud_done;
  logic                   push;
  logic                   ferr_set;
  logic                   drop;

  assign baud_done = (baud_cnt == '0);
  assign push      = (state == STOP) && baud_done && rx_s;
  assign ferr_set  = (state == STOP) && baud_done && !rx_s;

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rstn_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
    end
  end

  // Stop-bit handling returns to IDLE at mid-bit so a back-to-back start edge is not missed.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rstn_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            bit_cnt  <= '0;
            baud_cnt <= HALF_RELOAD;
            state    <= START;
          end
        end
        START: begin
          if (!baud_done) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            baud_cnt <= FULL_RELOAD;
            state    <= DATA;
          end
        end
        DATA: begin
          if (!baud_done) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            shift    <= {rx_s, shift[UART_DATA_W-1:1]};
            baud_cnt <= FULL_RELOAD;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (!baud_done) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  logic fifo_empty;
  logic fifo_full;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clk       (sys_clk_i),
    .resetn    (sys_rstn_i),
    .push      (push),
    .push_data (shift),
    .pop       (uart_rd_i),
    .head      (uart_dat_o),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign uart_valid_o = !fifo_empty;
  assign drop         = push && fifo_full && !uart_rd_i;
`else
  logic [UART_DATA_W-1:0] hold_dat;
  logic                   hold_valid;
  logic                   hold_pop;

  // Depth only matters for the FIFO build.
  if (FIFO_DEPTH < 1) begin : g_depth_unused
  end

  assign hold_pop     = uart_rd_i && hold_valid;
  assign uart_valid_o = hold_valid;
  assign uart_dat_o   = hold_valid ? hold_dat : '0;
  assign drop         = push && hold_valid && !uart_rd_i;

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rstn_i) begin
      hold_dat   <= '0;
      hold_valid <= 1'b0;
    end else if (push && (!hold_valid || hold_pop)) begin
      hold_dat   <= shift;
      hold_valid <= 1'b1;
    end else if (hold_pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // Set events are applied after the clear so they win a same-cycle tie.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rstn_i) begin
      uart_ovf_o  <= 1'b0;
      uart_ferr_o <= 1'b0;
    end else begin
      if (uart_clr_i) begin
        uart_ovf_o  <= 1'b0;
        uart_ferr_o <= 1'b0;
      end
      if (drop) begin
        uart_ovf_o <= 1'b1;
      end
      if (ferr_set) begin
        uart_ferr_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized bench for uart_rx against a queue-based receive model
module tb_uart_rx;

  localparam int C   = 16;
  localparam int LAT = 2 + C/2 + 9*C + 1;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rx   = 1'b1;
  logic       rd   = 1'b0;
  logic       clr  = 1'b0;
  logic [7:0] dat;
  logic       valid;
  logic       ovf;
  logic       ferr;

  uart_rx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (4)
  ) dut (
    .sys_clk_i    (clk),
    .sys_rstn_i   (rstn),
    .uart_rx_i    (rx),
    .uart_rd_i    (rd),
    .uart_clr_i   (clr),
    .uart_dat_o   (dat),
    .uart_valid_o (valid),
    .uart_ovf_o   (ovf),
    .uart_ferr_o  (ferr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [7:0] data;
    bit         is_ferr;
  } ev_t;

  int         cyc    = 0;
  int         errors = 0;
  int         checks = 0;
  ev_t        ev_q[$];
  logic [7:0] m_q[$];
  bit         m_ovf  = 0;
  bit         m_ferr = 0;

  // Model: each complete frame lands at a fixed cycle after its line fall.
  always @(posedge clk) begin
    ev_t e;
    int  occ;
    bit  popped;
    bit  set_o;
    bit  set_f;
    cyc++;
    if (!rstn) begin
      m_q.delete();
      ev_q.delete();
      m_ovf  = 0;
      m_ferr = 0;
    end else begin
      occ    = m_q.size();
      popped = rd && (occ > 0);
      set_o  = 0;
      set_f  = 0;
      if (popped) void'(m_q.pop_front());
      if (ev_q.size() > 0 && ev_q[0].at == cyc) begin
        e = ev_q.pop_front();
        if (e.is_ferr) set_f = 1;
        else if (occ < DEPTH || popped) m_q.push_back(e.data);
        else set_o = 1;
      end
      if (clr) begin
        m_ovf  = 0;
        m_ferr = 0;
      end
      if (set_o) m_ovf = 1;
      if (set_f) m_ferr = 1;
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_d;
    bit         exp_v;
    exp_v = (m_q.size() > 0);
    exp_d = exp_v ? m_q[0] : 8'h00;
    checks++;
    if ({valid, dat, ovf, ferr} !== {exp_v, exp_d, m_ovf, m_ferr}) begin
      errors++;
      $display("FAIL cycle_compare cyc=%0d valid/dat/ovf/ferr got %b/%h/%b/%b required %b/%h/%b/%b",
               cyc, valid, dat, ovf, ferr, exp_v, exp_d, m_ovf, m_ferr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input int nbits, input int gap);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    if (nbits == 10) ev_q.push_back('{at: cyc + LAT, data: b, is_ferr: !stop});
    for (int k = 0; k < nbits; k++) begin
      rx = bits[k];
      repeat (C) tick();
    end
    rx = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  int start;
  int lat;

  initial begin
    repeat (3) tick();
    check("reset_valid", valid, 0);
    check("reset_dat", dat, 0);
    check("reset_ovf", ovf, 0);
    check("reset_ferr", ferr, 0);
    rstn = 1'b1;
    tick();

    // Single byte with latency measured against the line fall.
    start = cyc;
    lat   = -1;
    fork
      send_frame(8'hA5, 1'b1, 10, 0);
      begin
        for (int n = 0; n < 300 && lat < 0; n++) begin
          tick();
          if (valid) lat = cyc - start;
        end
      end
    join
    check("single_latency", lat, 155);
    check("single_dat", dat, 8'hA5);
    check("single_flags", {ovf, ferr}, 2'b00);
    pop();
    check("single_pop_empty", valid, 0);

    // Start glitch.
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (20) tick();
    check("glitch_no_push", {valid, ovf, ferr}, 3'b000);
    send_frame(8'h3C, 1'b1, 10, 0);
    check("glitch_next_dat", dat, 8'h3C);
    pop();

    // Frame error.
    send_frame(8'h3C, 1'b0, 10, 20);
    check("ferr_set", {ferr, valid}, 2'b10);
    pulse_clr();
    check("ferr_clear", ferr, 0);

    // Overrun.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 10, 0);
    check("ovf_set", ovf, 1);
    for (int k = 0; k < DEPTH; k++) begin
      check("ovf_pop_dat", dat, 32'(k + 1));
      pop();
    end
    check("ovf_drained", valid, 0);
    pulse_clr();

    // Full buffer with a pop in the push cycle.
    for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h10 + i), 1'b1, 10, 0);
    fork
      send_frame(8'(8'h10 + DEPTH), 1'b1, 10, 0);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1;
        rd = 1'b1;
        tick();
        rd = 1'b0;
      end
    join
    check("full_pop_no_ovf", ovf, 0);
    for (int k = 0; k < DEPTH; k++) begin
      check("full_pop_dat", dat, 32'(8'h11 + k));
      pop();
    end
    check("full_drained", valid, 0);

    // Reset mid-frame with bytes buffered.
    send_frame(8'h21, 1'b1, 10, 0);
    send_frame(8'h22, 1'b1, 10, 0);
    send_frame(8'h77, 1'b1, 6, 0);
    rx   = 1'b0;
    rstn = 1'b0;
    repeat (2) tick();
    rx   = 1'b1;
    check("midreset_outputs", {valid, dat, ovf, ferr}, 11'h000);
    rstn = 1'b1;
    repeat (4) tick();
    check("after_reset_outputs", {valid, dat, ovf, ferr}, 11'h000);
    send_frame(8'h5A, 1'b1, 10, 0);
    check("after_reset_dat", dat, 8'h5A);
    pop();

    // Random frames with random pops and clears underneath.
    for (int f = 0; f < 40; f++) begin
      logic [7:0] b;
      bit         stop;
      b    = 8'($urandom);
      stop = ($urandom % 6) != 0;
      fork
        send_frame(b, stop, 10, stop ? int'($urandom % 4) : 20);
        begin
          for (int n = 0; n < 150; n++) begin
            rd  = ($urandom % 6) == 0;
            clr = ($urandom % 40) == 0;
            tick();
          end
          rd  = 1'b0;
          clr = 1'b0;
        end
      join
    end
    repeat (DEPTH + 1) pop();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive-side counterpart of the core's UART transmitter. It deserialises 8N1 frames from the FPGA `uart_rx` pin and buffers the received bytes. The core pops bytes with a load from the UART RX address; the core decodes that address and drives `uart_rd_i`. Sticky overrun and frame-error flags are exposed for status reads.

## Interface
- `CLKS_PER_BIT`, default 868: system clocks per bit (100 MHz / 115200); must be ≥ 8.
- `FIFO_DEPTH`, default 16: receive buffer entries; power of two, ≥ 2. Used only when `UART_RX_FIFO_EN` is defined.
- `sys_clk_i`  in  1  system clock; everything is on the rising edge.
- `sys_rstn_i`  in  1  reset, synchronous, active-low.
- `uart_rx_i`  in  1  serial line, asynchronous, idles high.
- `uart_rd_i`  in  1  one-cycle pop strobe (load from RX address).
- `uart_clr_i`  in  1  clears the sticky flags.
- `uart_dat_o`  out  8  head byte (show-ahead); `8'h00` when empty.
- `uart_valid_o`  out  1  buffer non-empty.
- `uart_ovf_o`  out  1  sticky: a byte was dropped because the buffer was full.
- `uart_ferr_o`  out  1  sticky: a stop bit was sampled low.

## Operation
- **Input synchroniser:** `uart_rx_i` passes through 2 flops; the synchroniser resets to 1. All logic uses the synchronised value `rx_s`.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** waits for `rx_s`=0, then loads the bit counter with 0 and the baud counter with `CLKS_PER_BIT/2 - 1`, and goes to START.
  - **START:** on baud expiry, samples `rx_s`.
    - 1 → false start; return to IDLE.
    - 0 → reload the baud counter with `CLKS_PER_BIT - 1` and go to DATA.
  - **DATA:** on each baud expiry, shifts `rx_s` into the shift register, LSB first. After bit index 7 it goes to STOP with the baud counter reloaded.
  - **STOP:** on baud expiry, samples `rx_s`.
    - 1 → push the byte.
    - 0 → discard the byte and set `uart_ferr_o`.
    - Either way, return to IDLE at mid-stop-bit so the receiver is ready for a back-to-back frame.
- **Baud counter:** counts down, width `$clog2(CLKS_PER_BIT)`. Expiry is at count 0.
- **Pop:** `uart_rd_i` while `uart_valid_o`=1 removes the head byte. `uart_rd_i` while empty is ignored; no state change and no flag.
- **Push while full without a pop:** the byte is dropped, `uart_ovf_o` is set, and the buffer contents are unchanged.
- **Push and pop in the same cycle:** legal at any occupancy, including full. The occupancy is unchanged and there is no overrun.
- **Sticky flags:** cleared only by `uart_clr_i` or reset. If `uart_clr_i` and a set event occur in the same cycle, set wins.
- **Occupancy and pointers:** the count is `$clog2(FIFO_DEPTH)+1` bits. The read/write pointers wrap modulo `FIFO_DEPTH`.

## Timing
- **Reset values:** FSM IDLE, buffer empty, `uart_valid_o`=0, `uart_dat_o`=0, `uart_ovf_o`=0, `uart_ferr_o`=0.
- **Reset mid-frame:** reset aborts the frame and discards the buffer contents.
- **Stop sample to valid:** the push occurs on the edge that samples the stop bit, so `uart_valid_o`=1 and `uart_dat_o` are valid in the following cycle.
- **Line fall to valid:** 2 (synchroniser) + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles, plus 1.
- **Pop:** the next byte, or the empty state, is visible the cycle after `uart_rd_i`.
- **Output timing:** `uart_dat_o` is combinational from the head entry. All flags are registered.

## Configuration
- **`UART_RX_FIFO_EN` defined:** a `FIFO_DEPTH`-entry circular buffer, behaving as described above.
- **`UART_RX_FIFO_EN` undefined:** a single holding register, i.e. depth 1.
  - A push while it is full drops the byte and sets `uart_ovf_o`.
  - A same-cycle pop and push still succeeds.
  - `FIFO_DEPTH` is ignored.
- The port list is identical in both builds.

## Structure
- **Shared package `uart_pkg`:**
  - `uart_rx_state_t` enum (IDLE, START, DATA, STOP).
  - `UART_DATA_W` = 8.
  - The default `CLKS_PER_BIT`.
- **Sub-module `uart_rx_fifo`:** a byte FIFO with push/pop, show-ahead data, and empty/full outputs. It is instantiated only under `UART_RX_FIFO_EN`.
- **Top level:** the FSM and the flags live in `uart_rx` itself.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `FIFO_DEPTH`=4.
- **Single byte:** send 0xA5 → `uart_valid_o`=1 exactly 2+8+144+1 cycles after the start edge. `uart_dat_o`=0xA5, both flags 0. Pop → `uart_valid_o`=0 next cycle.
- **Start glitch:** line low for 5 cycles, then high → FSM back in IDLE, no push, no flags. A following 0x3C is received correctly.
- **Frame error:** send 0x3C with the stop bit at 0 → `uart_ferr_o`=1, `uart_valid_o`=0. Pulse `uart_clr_i` → `uart_ferr_o`=0.
- **Overrun:** send 0x01–0x05 with no reads → `uart_ovf_o`=1. Pops return 0x01, 0x02, 0x03, 0x04, then empty.
- **Full buffer with simultaneous pop:** with the buffer full (0x10–0x13), pop in the cycle of the 0x14 push → no overrun. The contents become 0x11–0x14.
- **Reset mid-frame:** assert `sys_rstn_i`=0 during bit 4 of a frame while 2 bytes are buffered → all outputs return to reset values. A subsequent 0x5A is received intact.
